// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch
// Description : Sequential-PC instruction fetch with an in-order prefetch
//               buffer, redirect flush and stale-response discard.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch #(
    parameter int                DWIDTH   = 32,
    parameter int                WORDSIZE = 4,
    parameter logic [DWIDTH-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [DWIDTH-1:0] redirect_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [DWIDTH-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DWIDTH-1:0] imem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_pc,
    output logic [DWIDTH-1:0] out_instr
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     C_DEPTH = (CW + 1)'(DEPTH);

    logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]     head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [CW-1:0]     alloc_q, alloc_d, unfilled_q, unfilled_d, drop_q, drop_d;
    logic [DWIDTH-1:0] pc_mem_q    [DEPTH];
    logic [DWIDTH-1:0] instr_mem_q [DEPTH];

    logic [CW:0] occupancy;
    logic        req_fire, resp_drop, resp_fill, resp_counted, pop;

    assign occupancy      = {1'b0, alloc_q} + {1'b0, drop_q};
    assign imem_req_valid = !rst && (occupancy < C_DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop    = imem_resp_valid && (drop_q != '0);
    assign resp_fill    = imem_resp_valid && (drop_q == '0) && (unfilled_q != '0);
    assign resp_counted = resp_drop || resp_fill;

    // Entries fill in order behind head, so head is filled iff any entry is.
    assign out_valid = (alloc_q != unfilled_q);
    assign out_pc    = pc_mem_q[head_q];
    assign out_instr = instr_mem_q[head_q];
    assign pop       = out_valid && out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        alloc_d    = alloc_q;
        unfilled_d = unfilled_q;
        drop_d     = drop_q;
        if (redirect) begin
            // Everything still in flight, including this cycle's request, is stale.
            fetch_pc_d = redirect_target;
            head_d     = tail_q;
            fill_d     = tail_q;
            alloc_d    = '0;
            unfilled_d = '0;
            drop_d     = drop_q + unfilled_q + CW'(req_fire) - CW'(resp_counted);
        end else begin
            if (req_fire) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = fetch_pc_q + DWIDTH'(WORDSIZE);
            end
            if (resp_drop) drop_d = drop_q - CW'(1);
            if (resp_fill) fill_d = fill_q + PW'(1);
            if (pop)       head_d = head_q + PW'(1);
            alloc_d    = alloc_q + CW'(req_fire) - CW'(pop);
            unfilled_d = unfilled_q + CW'(req_fire) - CW'(resp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            alloc_q    <= '0;
            unfilled_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            alloc_q    <= alloc_d;
            unfilled_q <= unfilled_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire && !redirect) pc_mem_q[tail_q] <= fetch_pc_q;
        if (resp_fill && !redirect) instr_mem_q[fill_q] <= imem_resp_data;
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means the memory broke the protocol.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && alloc_q == '0 && drop_q == '0));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized traffic against an epoch-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, redirect, imem_req_ready, imem_resp_valid, out_ready;
    logic [31:0] redirect_target, imem_resp_data;
    logic        imem_req_valid, out_valid;
    logic [31:0] imem_req_addr, out_pc, out_instr;

    always #5 clk = ~clk;

    fetch_prefetch #(
        .DWIDTH(32), .WORDSIZE(4), .RESET_PC(32'h0), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; int ep; } fl_t;
    mreq_t       memq[$];
    fl_t         inflight[$];
    logic [31:0] readyq[$];
    logic [31:0] m_fetch;
    int          m_ep;
    bit          model_on = 1'b0;

    logic        s_rv, s_ov, s_resp;
    logic [31:0] s_addr, s_pc, s_instr;

    typedef struct {
        logic        rst, rdy, ordy, redir;
        logic [31:0] tgt;
        logic        chk, e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [31:0] h(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic ordy,
                         input logic redir, input logic [31:0] tgt);
        rst = r; imem_req_ready = rdy; out_ready = ordy;
        redirect = redir; redirect_target = tgt;
    endtask

    // One clock: memory drives its response, outputs are checked against the
    // model before the edge, then memory and model advance at the edge.
    task automatic cycle();
        logic e_rv, e_ov, fire, pop;
        fl_t  f;
        if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = h(memq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEADBEEF;
        end
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_ov = out_valid;
        s_pc = out_pc; s_instr = out_instr; s_resp = imem_resp_valid;
        e_rv = !rst && (inflight.size() + readyq.size() < DEPTH);
        e_ov = readyq.size() > 0;
        if (model_on) begin
            check("req_valid", 32'(s_rv), 32'(e_rv));
            if (e_rv) check("req_addr", s_addr, m_fetch);
            check("out_valid", 32'(s_ov), 32'(e_ov));
            if (e_ov) begin
                check("out_pc", s_pc, readyq[0]);
                check("out_instr", s_instr, h(readyq[0]));
            end
        end
        @(posedge clk);
        fire = e_rv && imem_req_ready;
        pop  = e_ov && out_ready;
        if (rst) begin
            memq.delete(); inflight.delete(); readyq.delete();
            m_fetch = 32'h0; m_ep = 0; model_on = 1'b1;
        end else begin
            if (s_resp) void'(memq.pop_front());
            if (s_rv && imem_req_ready) memq.push_back('{s_addr, cyc + lat});
            if (s_resp && inflight.size() > 0) begin
                f = inflight.pop_front();
                if (f.ep == m_ep) readyq.push_back(f.pc);
            end
            if (pop) void'(readyq.pop_front());
            if (fire) inflight.push_back('{m_fetch, m_ep});
            if (redirect) begin
                m_ep++;
                readyq.delete();
                m_fetch = redirect_target;
            end else if (fire) begin
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_pop(input string nm, input logic [31:0] exp);
        bit got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle();
            if (s_ov && out_ready) begin
                got = 1'b1;
                check(nm, s_pc, exp);
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL %s: got no output within 30 cycles expected %h", nm, exp);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle();
        cycle();
    endtask

    int nf;

    initial begin
        //          rst   rdy   ordy  redir tgt    chk   e_rv  e_addr  e_ov  e_pc
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

        lat = 1;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].ordy, tbl[i].redir, tbl[i].tgt);
            cycle();
            if (tbl[i].chk) begin
                check("tbl_req_valid", 32'(s_rv), 32'(tbl[i].e_rv));
                if (tbl[i].e_rv) check("tbl_req_addr", s_addr, tbl[i].e_addr);
                check("tbl_out_valid", 32'(s_ov), 32'(tbl[i].e_ov));
                if (tbl[i].e_ov) begin
                    check("tbl_out_pc", s_pc, tbl[i].e_pc);
                    check("tbl_out_instr", s_instr, h(tbl[i].e_pc));
                end
            end
        end

        // Buffer full with decode stalled, then drain.
        do_reset();
        lat = 1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        nf = 0;
        repeat (10) begin
            cycle();
            if (s_rv && imem_req_ready) nf++;
        end
        check("full_accepts", 32'(nf), 32'd4);
        check("full_req_low", 32'(s_rv), 32'd0);
        out_ready = 1'b1;
        wait_pop("drain_first", 32'h0);
        repeat (12) cycle();

        // Redirect with two long-latency requests in flight.
        do_reset();
        lat = 3;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle();
        cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_pop("redir_l3_first", 32'h100);
        repeat (8) cycle();

        // Redirect coinciding with request, response and pop.
        do_reset();
        lat = 1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (8) cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000);
        cycle();
        check("combo_fire", 32'(s_rv), 32'd1);
        check("combo_resp", 32'(s_resp), 32'd1);
        check("combo_pop", 32'(s_ov), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_pop("combo_first", 32'h2000);

        // Fetch PC wraps past the top of the address space.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC);
        cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle();
        check("wrap_addr_top", s_addr, 32'hFFFFFFFC);
        cycle();
        check("wrap_addr_zero", s_addr, 32'h0);
        repeat (8) cycle();

        // Randomized traffic, including redirects and mid-run resets.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                  $urandom & 32'hFFFFFFFC);
            lat = $urandom_range(1, 4);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
